// File: rtl/simmem_row_delay_sched.sv
// Row-buffer aware write-response delay scheduler for the simulated memory.
// Tags each accepted write address with the absolute cycle its response may leave.
package simmem_pkg;
  localparam int unsigned RowHitCost        = 10;
  localparam int unsigned PrechargeCost     = 50;
  localparam int unsigned ActivationCost    = 45;
  localparam int unsigned MaxBurstLen       = 4;
  localparam int unsigned IDWidth           = 4;
  localparam int unsigned AxAddrWidth       = 16;
  localparam int unsigned AxLenWidth        = 8;
  localparam int unsigned TimestampWidth    = 20;
  localparam int unsigned RowBufferLenWidth = 8;
endpackage

module simmem_row_delay_sched #(
  parameter int unsigned RowHitCost     = simmem_pkg::RowHitCost,
  parameter int unsigned PrechargeCost  = simmem_pkg::PrechargeCost,
  parameter int unsigned ActivationCost = simmem_pkg::ActivationCost,
  parameter int unsigned MaxBurstLen    = simmem_pkg::MaxBurstLen,
  parameter int unsigned TimestampWidth = simmem_pkg::TimestampWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 addr_valid_i,
  output logic                                 addr_ready_o,
  input  logic [simmem_pkg::IDWidth-1:0]       addr_id_i,
  input  logic [simmem_pkg::AxAddrWidth-1:0]   addr_i,
  input  logic [simmem_pkg::AxLenWidth-1:0]    burst_len_i,
  output logic                                 rel_valid_o,
  input  logic                                 rel_ready_i,
  output logic [simmem_pkg::IDWidth-1:0]       rel_id_o,
  output logic [TimestampWidth-1:0]            rel_timestamp_o,
  output logic [TimestampWidth-1:0]            now_o
);

  localparam int unsigned TsW  = TimestampWidth;
  localparam int unsigned IdW  = simmem_pkg::IDWidth;
  localparam int unsigned LenW = simmem_pkg::AxLenWidth;
  localparam int unsigned AddrW = simmem_pkg::AxAddrWidth;
  localparam int unsigned RowLsb = simmem_pkg::RowBufferLenWidth;
  localparam int unsigned RowW = AddrW - RowLsb;

  localparam logic [LenW-1:0] LenCap = LenW'(MaxBurstLen - 1);
  localparam logic [TsW-1:0] CostHit = TsW'(RowHitCost);
  localparam logic [TsW-1:0] CostClosed = TsW'(ActivationCost + RowHitCost);
  localparam logic [TsW-1:0] CostMiss =
    TsW'(PrechargeCost + ActivationCost + RowHitCost);

  logic [TsW-1:0]  r_now;
  logic [TsW-1:0]  r_busy_until;
  logic            r_busy_q;
  logic            r_row_open;
  logic [RowW-1:0] r_open_row;
  logic            r_rel_valid;
  logic [IdW-1:0]  r_rel_id;
  logic [TsW-1:0]  r_rel_ts;

  logic            w_ready;
  logic            w_accept;
  logic            w_busy;
  logic [RowW-1:0] w_row;
  logic [LenW-1:0] w_len_eff;
  logic [TsW-1:0]  w_base;
  logic [TsW-1:0]  w_start;
  logic [TsW-1:0]  w_release;

  assign w_ready  = !r_rel_valid || rel_ready_i;
  assign w_accept = addr_valid_i && w_ready;
  assign w_row    = addr_i[AddrW-1:RowLsb];

  // Equality, not ordering: the busy window must survive timestamp wrap.
  assign w_busy  = r_busy_q && (r_now != r_busy_until);
  assign w_start = w_busy ? r_busy_until : r_now;

  assign w_len_eff = (burst_len_i > LenCap) ? LenCap : burst_len_i;

  always_comb begin
    w_base = CostHit;
    if (!r_row_open) begin
      w_base = CostClosed;
    end else if (w_row != r_open_row) begin
      w_base = CostMiss;
    end
  end

  assign w_release = w_start + w_base + TsW'(w_len_eff);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_now        <= '0;
      r_busy_until <= '0;
      r_busy_q     <= 1'b0;
      r_row_open   <= 1'b0;
      r_open_row   <= '0;
      r_rel_valid  <= 1'b0;
      r_rel_id     <= '0;
      r_rel_ts     <= '0;
    end else begin
      r_now <= r_now + TsW'(1);
      if (w_accept) begin
        r_rel_valid  <= 1'b1;
        r_rel_id     <= addr_id_i;
        r_rel_ts     <= w_release;
        r_busy_q     <= 1'b1;
        r_busy_until <= w_release;
        r_row_open   <= 1'b1;
        r_open_row   <= w_row;
      end else begin
        if (rel_ready_i) begin
          r_rel_valid <= 1'b0;
        end
        if (r_now == r_busy_until) begin
          r_busy_q <= 1'b0;
        end
      end
    end
  end

  assign addr_ready_o    = w_ready;
  assign rel_valid_o     = r_rel_valid;
  assign rel_id_o        = r_rel_id;
  assign rel_timestamp_o = r_rel_ts;
  assign now_o           = r_now;

endmodule

// File: tb/tb_simmem_row_delay_sched.sv
// Bench for simmem_row_delay_sched: directed scenarios plus random traffic
// against an unwrapped-time reference model. A 12-bit timestamp keeps wrap reachable.
module tb_simmem_row_delay_sched;

  localparam int unsigned TW = 12;
  localparam longint MOD = 64'd1 << TW;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          addr_valid_i;
  logic          addr_ready_o;
  logic [3:0]    addr_id_i;
  logic [15:0]   addr_i;
  logic [7:0]    burst_len_i;
  logic          rel_valid_o;
  logic          rel_ready_i;
  logic [3:0]    rel_id_o;
  logic [TW-1:0] rel_timestamp_o;
  logic [TW-1:0] now_o;

  simmem_row_delay_sched #(.TimestampWidth(TW)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .addr_valid_i(addr_valid_i),
    .addr_ready_o(addr_ready_o),
    .addr_id_i(addr_id_i),
    .addr_i(addr_i),
    .burst_len_i(burst_len_i),
    .rel_valid_o(rel_valid_o),
    .rel_ready_i(rel_ready_i),
    .rel_id_o(rel_id_o),
    .rel_timestamp_o(rel_timestamp_o),
    .now_o(now_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Model: time is kept unwrapped; the memory is busy until the last release.
  longint m_now;
  longint m_last_rel;
  bit     m_open;
  bit [7:0] m_row;
  bit     m_valid;
  int     m_id;
  longint m_ts;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_now = 0;
    m_last_rel = 0;
    m_open = 0;
    m_row = 0;
    m_valid = 0;
    m_id = 0;
    m_ts = 0;
  endtask

  task automatic model_step();
    bit acc;
    int cost;
    longint start;
    bit [7:0] row;
    if (rst_i) begin
      model_reset();
      return;
    end
    acc = addr_valid_i && (!m_valid || rel_ready_i);
    if (acc) begin
      row = addr_i[15:8];
      if (!m_open) cost = 55;
      else if (row == m_row) cost = 10;
      else cost = 105;
      cost += (burst_len_i > 8'd3) ? 3 : int'(burst_len_i);
      start = (m_last_rel > m_now) ? m_last_rel : m_now;
      m_last_rel = start + cost;
      m_ts = m_last_rel % MOD;
      m_valid = 1;
      m_id = int'(addr_id_i);
      m_open = 1;
      m_row = row;
    end else if (rel_ready_i) begin
      m_valid = 0;
    end
    m_now++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("now", longint'(now_o), m_now % MOD);
      chk("rel_valid", longint'(rel_valid_o), longint'(m_valid));
      chk("addr_ready", longint'(addr_ready_o),
          longint'(!m_valid || rel_ready_i));
      if (m_valid) begin
        chk("rel_id", longint'(rel_id_o), longint'(m_id));
        chk("rel_ts", longint'(rel_timestamp_o), m_ts);
      end
      if (rst_i) begin
        chk("rst_id", longint'(rel_id_o), 0);
        chk("rst_ts", longint'(rel_timestamp_o), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic drive(input bit v, input int id, input int a,
                       input int len, input bit rdy);
    addr_valid_i = v;
    addr_id_i = 4'(id);
    addr_i = 16'(a);
    burst_len_i = 8'(len);
    rel_ready_i = rdy;
  endtask

  task automatic cyc(input bit v, input int id, input int a,
                     input int len, input bit rdy);
    drive(v, id, a, len, rdy);
    step();
  endtask

  task automatic idle_until(input longint t);
    int budget;
    budget = int'(MOD) + 16;
    while ((m_now % MOD) != t && budget > 0) begin
      cyc(0, 0, 0, 0, 1);
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL idle_until timeout: now %0d wanted %0d", m_now % MOD, t);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_i = 1'b1;
    model_reset();
    repeat (cycles) step();
    rst_i = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 1);
    rst_i = 1'b1;
    model_reset();
    step();
    chk_en = 1'b1;
    step();
    chk("reset_now", longint'(now_o), 0);
    chk("reset_valid", longint'(rel_valid_o), 0);
    chk("reset_ready", longint'(addr_ready_o), 1);
    chk("reset_ts", longint'(rel_timestamp_o), 0);
    rst_i = 1'b0;

    idle_until(5);
    cyc(1, 3, 'h1234, 0, 1);
    chk("closed_ts", longint'(rel_timestamp_o), 60);
    chk("closed_model", m_ts, 60);
    chk("closed_valid", longint'(rel_valid_o), 1);
    chk("closed_id", longint'(rel_id_o), 3);

    idle_until(70);
    cyc(1, 4, 'h12FF, 3, 1);
    chk("hit_ts", longint'(rel_timestamp_o), 83);
    chk("hit_model", m_ts, 83);

    idle_until(75);
    cyc(1, 5, 'h3400, 0, 1);
    chk("miss_ts", longint'(rel_timestamp_o), 188);
    chk("miss_model", m_ts, 188);

    for (int i = 0; i < 10; i++) begin
      cyc(1, 6, 'h3456, 1, 0);
      chk("hold_ready", longint'(addr_ready_o), 0);
      chk("hold_ts", longint'(rel_timestamp_o), 188);
      chk("hold_id", longint'(rel_id_o), 5);
    end
    drive(1, 6, 'h3456, 1, 1);
    #1;
    chk("release_ready", longint'(addr_ready_o), 1);
    step();
    chk("replace_ts", longint'(rel_timestamp_o), 199);
    chk("replace_id", longint'(rel_id_o), 6);
    chk("replace_valid", longint'(rel_valid_o), 1);

    cyc(0, 0, 0, 0, 0);
    rst_i = 1'b1;
    model_reset();
    #1;
    chk("async_valid", longint'(rel_valid_o), 0);
    chk("async_ts", longint'(rel_timestamp_o), 0);
    chk("async_now", longint'(now_o), 0);
    chk("async_ready", longint'(addr_ready_o), 1);
    step();
    step();
    rst_i = 1'b0;
    idle_until(3);
    cyc(1, 7, 'h3400, 2, 1);
    chk("post_rst_ts", longint'(rel_timestamp_o), 60);

    for (int i = 0; i < 3000; i++) begin
      bit v;
      int a;
      int len;
      v = ($urandom_range(2) == 0) && ((m_last_rel - m_now) < 1500);
      a = ((16 + $urandom_range(3)) << 8) | $urandom_range(255);
      len = ($urandom_range(1) == 0) ? $urandom_range(4) : $urandom_range(255);
      if ($urandom_range(499) == 0) begin
        do_reset(1);
      end else begin
        cyc(v, $urandom_range(15), a, len, $urandom_range(3) != 0);
      end
    end

    do_reset(1);
    idle_until(MOD - 16);
    cyc(1, 9, 'hABCD, 0, 1);
    chk("wrap_ts", longint'(rel_timestamp_o), 'h027);
    chk("wrap_model", m_ts, 'h027);
    idle_until('h027);
    cyc(1, 10, 'hAB00, 0, 1);
    chk("wrap_hit_ts", longint'(rel_timestamp_o), 'h031);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/simmem_row_delay_sched.md
SIMMEM_ROW_DELAY_SCHED -- requirements
Module: simmem_row_delay_sched

Interface
REQ-001 SHALL have parameters (name, default, meaning): RowHitCost, 10, cycles for a row-buffer hit (at least 1); PrechargeCost, 50, cycles to close an open row; ActivationCost, 45, cycles to open a row; MaxBurstLen, 4, maximum beats charged per request. All defaults come from simmem_pkg.
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port addr_valid_i, input, 1: a write-address request is presented.
REQ-005 SHALL have port addr_ready_o, output, 1: the block accepts the request this cycle.
REQ-006 SHALL have port addr_id_i, input, IDWidth (4): AXI ID of the request.
REQ-007 SHALL have port addr_i, input, AxAddrWidth (16): request address.
REQ-008 SHALL have port burst_len_i, input, AxLenWidth (8): AXI burst_length (beats minus 1).
REQ-009 SHALL have port rel_valid_o, output, 1: a release entry is valid.
REQ-010 SHALL have port rel_ready_i, input, 1: downstream response bank consumes the entry.
REQ-011 SHALL have port rel_id_o, output, IDWidth: ID of the released entry.
REQ-012 SHALL have port rel_timestamp_o, output, TimestampWidth (20): absolute cycle at which the response may be released.
REQ-013 SHALL have port now_o, output, TimestampWidth: current free-running timestamp.

Function
REQ-014 now_o SHALL increment by 1 every cycle and wrap modulo 2^20.
REQ-015 addr_ready_o SHALL equal (!rel_valid_o || rel_ready_i). This is combinational, with a single output register.
REQ-016 A request SHALL be accepted only when addr_valid_i and addr_ready_o are both 1 on a rising clk_i edge.
REQ-017 row SHALL be addr_i[15:8] (AxAddrWidth-1 down to RowBufferLenWidth).
REQ-018 Classification at acceptance SHALL be:
- closed if row_open=0;
- hit if row_open=1 and row equals open_row;
- miss otherwise.
REQ-019 The cost SHALL be:
- closed: ActivationCost+RowHitCost (55);
- hit: RowHitCost (10);
- miss: PrechargeCost+ActivationCost+RowHitCost (105);
- plus min(burst_len_i, MaxBurstLen-1) extra cycles (0..3).
REQ-020 busy SHALL be defined as busy_q && (now != busy_until). start SHALL be busy_until if busy, else now.
REQ-021 The release timestamp SHALL be start+cost, computed modulo 2^20. Wrap-around SHALL NOT saturate.
REQ-022 On acceptance, on the same edge, the block SHALL:
- load rel_id_o and rel_timestamp_o;
- set rel_valid_o=1;
- set busy_until=release and busy_q=1;
- set open_row=row and row_open=1.
REQ-023 busy_q SHALL clear on the edge where now==busy_until and no acceptance occurs. If an acceptance occurs on that edge, the acceptance wins.
REQ-024 rel_valid_o SHALL clear when rel_ready_i=1 and no new acceptance occurs on that edge.
REQ-025 If an acceptance and a consumption occur on the same edge, the new entry SHALL replace the old one with no bubble.
REQ-026 While rel_valid_o=1 and rel_ready_i=0, rel_id_o and rel_timestamp_o SHALL hold stable, and no request SHALL be accepted.
REQ-027 Results SHALL be in order. Latency from acceptance to rel_valid_o SHALL be 1 cycle.

Reset
REQ-028 While rst_i=1, asynchronously, the block SHALL set: now=0, rel_valid_o=0, rel_id_o=0, rel_timestamp_o=0, busy_q=0, busy_until=0, row_open=0, open_row=0. addr_ready_o SHALL consequently read 1.
REQ-029 Reset asserted mid-operation SHALL discard any pending entry. The first request after reset SHALL be classified closed.

Verification
REQ-030 Reset, then accept addr=0x1234, burst_len=0, at now=5 -> closed; rel_timestamp_o=60 one cycle later; open_row=0x12.
REQ-031 Continuing, accept addr=0x12FF, burst_len=3, at now=70 -> hit, not busy; release=83.
REQ-032 Continuing, accept addr=0x3400, burst_len=0, at now=75 -> busy until 83, miss; release=188.
REQ-033 Hold rel_ready_i=0 for 10 cycles with addr_valid_i=1 -> addr_ready_o=0, outputs stable. Raise rel_ready_i -> the next request is accepted on that same edge.
REQ-034 Accept a closed request at now=0xFFFF0 -> release=0x00027 (wrapped). busy_q clears when now=0x00027.
REQ-035 Assert rst_i while rel_valid_o=1 -> outputs reach their reset values immediately. The next request with the previous row is classified closed (+55).
